// File: rtl/com_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default CRC
// polynomial and the bit map of the sticky error vector.
package com_pkg;

   localparam logic [7:0]  CRC_POLY_DEFAULT = 8'h07;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ERR_W  = 4;

   // Positions inside the sticky error vector
   localparam int unsigned ERR_FRAMING  = 0;
   localparam int unsigned ERR_PARITY   = 1;
   localparam int unsigned ERR_OVERFLOW = 2;
   localparam int unsigned ERR_GLITCH   = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      PUSH   = 3'd5,
      WAITHI = 3'd6
   } rxState_t;

endpackage

// File: rtl/com_to_fifo_if.sv
// Write-side handshake between the UART receiver and its downstream FIFO.
interface com_to_fifo_if;
   import com_pkg::*;

   logic              fifo_busy;
   logic              fifo_full;
   logic              fifo_we;
   logic [BYTE_W-1:0] forSent;

   modport master (
      input  fifo_busy,
      input  fifo_full,
      output fifo_we,
      output forSent
   );

   modport slave (
      output fifo_busy,
      output fifo_full,
      input  fifo_we,
      input  forSent
   );

endinterface

// File: rtl/crc8_step.sv
// Byte-wide MSB-first CRC8 update (no reflection, no final XOR), purely
// combinational so a whole byte folds into the CRC in one clock.
module crc8_step
   import com_pkg::*;
#(
   parameter logic [7:0] POLY = CRC_POLY_DEFAULT
) (
   input  logic [7:0] crcIn,
   input  logic [7:0] dataIn,
   output logic [7:0] crcOut_c
);

   logic [7:0] crcWork;

   // Eight unrolled shift/XOR steps
   always_comb begin
      crcWork = crcIn ^ dataIn;
      for (int i = 0; i < 8; i++) begin
         if (crcWork[7]) begin
            crcWork = (crcWork << 1) ^ POLY;
         end else begin
            crcWork = crcWork << 1;
         end
      end
      crcOut_c = crcWork;
   end

endmodule

// File: rtl/com_to_fifo.sv
// Oversampling UART receiver that pushes each good byte into a FIFO and keeps
// a running CRC8. Define RX_PARITY_EN for 11-bit frames with even parity.
module com_to_fifo
   import com_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 16,
   parameter logic [7:0]  CRC_POLY   = CRC_POLY_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rx,
   com_to_fifo_if.master     fifoBus,
   output logic [BYTE_W-1:0] out_data,
   output logic [BYTE_W-1:0] CRC,
   output logic [ERR_W-1:0]  error,
   output logic              isFinish
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

   rxState_t          state;
   rxState_t          stateNext;

   logic              rxMeta;
   logic              rxSync;

   logic [CNT_W-1:0]  sampleCnt;
   logic [CNT_W-1:0]  cntNext;
   logic [2:0]        bitCnt;
   logic [2:0]        bitNext;
   logic [BYTE_W-1:0] shiftReg;
   logic [BYTE_W-1:0] shiftNext;

   logic              fifoWeQ;
   logic              weNext;
   logic [BYTE_W-1:0] forSentQ;
   logic [BYTE_W-1:0] forSentNext;
   logic [BYTE_W-1:0] outNext;
   logic [BYTE_W-1:0] crcNext;
   logic [BYTE_W-1:0] crcStep_c;
   logic [ERR_W-1:0]  errNext;

   logic              sampleHalf;
   logic              sampleFull;

   assign fifoBus.fifo_we = fifoWeQ;
   assign fifoBus.forSent = forSentQ;

   assign sampleHalf = (sampleCnt == HALF_LAST);
   assign sampleFull = (sampleCnt == BIT_LAST);

   crc8_step #(
      .POLY (CRC_POLY)
   ) uCrc (
      .crcIn    (CRC),
      .dataIn   (shiftReg),
      .crcOut_c (crcStep_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and datapath update
   always_comb begin
      stateNext   = state;
      cntNext     = sampleCnt + CNT_W'(1);
      bitNext     = bitCnt;
      shiftNext   = shiftReg;
      weNext      = 1'b0;
      forSentNext = forSentQ;
      outNext     = out_data;
      crcNext     = CRC;
      errNext     = error;

      if (!enable) begin
         stateNext = IDLE;
         cntNext   = '0;
         bitNext   = '0;
      end else begin
         case (state)
            IDLE: begin
               cntNext = '0;
               bitNext = '0;
               if (!rxSync) begin
                  stateNext = START;
               end
            end

            // Re-check the start bit at its midpoint to reject short glitches
            START: begin
               if (sampleHalf) begin
                  cntNext = '0;
                  if (rxSync) begin
                     errNext[ERR_GLITCH] = 1'b1;
                     stateNext           = IDLE;
                  end else begin
                     stateNext = DATA;
                  end
               end
            end

            DATA: begin
               if (sampleFull) begin
                  cntNext   = '0;
                  shiftNext = {rxSync, shiftReg[BYTE_W-1:1]};
                  bitNext   = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) begin
`ifdef RX_PARITY_EN
                     stateNext = PARITY;
`else
                     stateNext = STOP;
`endif
                  end
               end
            end

`ifdef RX_PARITY_EN
            // Even parity: a mismatch is flagged but the byte is still kept
            PARITY: begin
               if (sampleFull) begin
                  cntNext = '0;
                  if ((^shiftReg) ^ rxSync) begin
                     errNext[ERR_PARITY] = 1'b1;
                  end
                  stateNext = STOP;
               end
            end
`endif

            STOP: begin
               if (sampleFull) begin
                  cntNext = '0;
                  if (rxSync) begin
                     stateNext = PUSH;
                  end else begin
                     errNext[ERR_FRAMING] = 1'b1;
                     stateNext            = WAITHI;
                  end
               end
            end

            // Full beats busy: an overflowing byte is dropped immediately
            PUSH: begin
               cntNext = '0;
               if (fifoBus.fifo_full) begin
                  errNext[ERR_OVERFLOW] = 1'b1;
                  stateNext             = IDLE;
               end else if (!fifoBus.fifo_busy) begin
                  weNext      = 1'b1;
                  forSentNext = shiftReg;
                  outNext     = shiftReg;
                  crcNext     = crcStep_c;
                  stateNext   = IDLE;
               end
            end

            WAITHI: begin
               cntNext = '0;
               if (rxSync) begin
                  stateNext = IDLE;
               end
            end

            default: begin
               cntNext   = '0;
               stateNext = IDLE;
            end
         endcase
      end

`ifdef RX_PARITY_EN
      errNext[ERR_PARITY] = errNext[ERR_PARITY];
`else
      errNext[ERR_PARITY] = 1'b0;
`endif
   end

   // Synchronizer, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta    <= 1'b1;
         rxSync    <= 1'b1;
         sampleCnt <= '0;
         bitCnt    <= '0;
         shiftReg  <= '0;
         fifoWeQ   <= 1'b0;
         isFinish  <= 1'b0;
         forSentQ  <= '0;
         out_data  <= '0;
         CRC       <= '0;
         error     <= '0;
      end else begin
         rxMeta    <= rx;
         rxSync    <= rxMeta;
         sampleCnt <= cntNext;
         bitCnt    <= bitNext;
         shiftReg  <= shiftNext;
         fifoWeQ   <= weNext;
         isFinish  <= weNext;
         forSentQ  <= forSentNext;
         out_data  <= outNext;
         CRC       <= crcNext;
         error     <= errNext;
      end
   end

endmodule
